// File: rtl/wb_queue.sv
// Writeback queue: merges load-unit and ALU results into one register-file write port,
// with youngest-entry forwarding to the register read stage.
module wb_queue #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        lsu_valid,
    output logic                        lsu_ready,
    input  logic [ADDR_WIDTH-1:0]       lsu_rd,
    input  logic [WIDTH-1:0]            lsu_data,
    input  logic                        alu_valid,
    output logic                        alu_ready,
    input  logic [ADDR_WIDTH-1:0]       alu_rd,
    input  logic [WIDTH-1:0]            alu_data,
    output logic                        rf_wen,
    output logic [ADDR_WIDTH-1:0]       rf_addrw,
    output logic [WIDTH-1:0]            rf_dinw,
    input  logic [ADDR_WIDTH-1:0]       qa_addr,
    input  logic [ADDR_WIDTH-1:0]       qb_addr,
    output logic                        fwd_a_hit,
    output logic                        fwd_b_hit,
    output logic [WIDTH-1:0]            fwd_a_data,
    output logic [WIDTH-1:0]            fwd_b_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty,
    output logic                        full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] rd_q   [DEPTH];
    logic [WIDTH-1:0]      data_q [DEPTH];
    logic [PW-1:0]         wptr, rptr;
    logic [CW-1:0]         count_r;

    logic        pop;
    logic [CW:0] free_slots;
    logic        lsu_push, alu_push;
    logic [PW-1:0] alu_slot;

    // The head pops every cycle it exists, so its slot counts as free for this cycle's pushes.
    assign pop        = (count_r != '0);
    assign free_slots = DEPTH_W - {1'b0, count_r} + {{CW{1'b0}}, pop};
    assign lsu_ready  = (free_slots >= (CW+1)'(1));
    assign alu_ready  = (free_slots >= (CW+1)'(2)) ||
                        ((free_slots >= (CW+1)'(1)) && !lsu_valid);

    // rd = 0 is the hard-wired zero register: handshake completes, nothing is stored.
    assign lsu_push = lsu_valid && lsu_ready && (lsu_rd != '0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
    assign alu_slot = wptr + PW'(lsu_push);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_r <= '0;
        end else begin
            wptr    <= wptr + PW'(lsu_push) + PW'(alu_push);
            rptr    <= rptr + PW'(pop);
            count_r <= count_r + CW'(lsu_push) + CW'(alu_push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (lsu_push) begin
                rd_q[wptr]   <= lsu_rd;
                data_q[wptr] <= lsu_data;
            end
            if (alu_push) begin
                rd_q[alu_slot]   <= alu_rd;
                data_q[alu_slot] <= alu_data;
            end
        end
    end

    assign rf_wen   = pop;
    assign rf_addrw = pop ? rd_q[rptr]   : '0;
    assign rf_dinw  = pop ? data_q[rptr] : '0;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        fwd_a_hit  = 1'b0;
        fwd_b_hit  = 1'b0;
        fwd_a_data = '0;
        fwd_b_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count_r) begin
                if ((qa_addr != '0) && (rd_q[rptr + PW'(k)] == qa_addr)) begin
                    fwd_a_hit  = 1'b1;
                    fwd_a_data = data_q[rptr + PW'(k)];
                end
                if ((qb_addr != '0) && (rd_q[rptr + PW'(k)] == qb_addr)) begin
                    fwd_b_hit  = 1'b1;
                    fwd_b_data = data_q[rptr + PW'(k)];
                end
            end
        end
    end

    assign count = count_r;
    assign empty = (count_r == '0);
    assign full  = (count_r == CW'(DEPTH));

endmodule

// File: tb/tb_wb_queue.sv
// Directed and random checks of wb_queue against hand-computed values and a queue model.
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, alu_valid;
    logic        lsu_ready, alu_ready;
    logic [4:0]  lsu_rd, alu_rd, qa_addr, qb_addr, rf_addrw;
    logic [31:0] lsu_data, alu_data, rf_dinw, fwd_a_data, fwd_b_data;
    logic        rf_wen, fwd_a_hit, fwd_b_hit, empty, full;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    wb_queue #(.WIDTH(32), .ADDR_WIDTH(5), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .rf_wen(rf_wen), .rf_addrw(rf_addrw), .rf_dinw(rf_dinw),
        .qa_addr(qa_addr), .qb_addr(qb_addr),
        .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
        .count(count), .empty(empty), .full(full)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lsu_valid = 1'b0; alu_valid = 1'b0;
        lsu_rd = '0; alu_rd = '0; lsu_data = '0; alu_data = '0;
        qa_addr = '0; qb_addr = '0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h1234;
        tick(); tick();
        rst = 1'b0;
        idle();
        qa_addr = 5'd4; qb_addr = 5'd4;
        #1;
        total++;
        if ({count, empty, full, rf_wen} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: count/empty/full/wen got %b want 000_1_0_0", {count, empty, full, rf_wen});
        end
        total++;
        if ({fwd_a_hit, fwd_b_hit, lsu_ready, alu_ready} !== 4'b0011) begin
            bad++;
            $display("FAIL reset_hits_ready: got %b want 0011", {fwd_a_hit, fwd_b_hit, lsu_ready, alu_ready});
        end
        total++;
        if ({rf_addrw, rf_dinw} !== 37'd0) begin
            bad++;
            $display("FAIL reset_rf_zero: addr %0d data %h want 0 0", rf_addrw, rf_dinw);
        end
    endtask

    task automatic test_single_lsu();
        idle();
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'hAAAA0001;
        tick();
        idle();
        #1;
        total++;
        if ({rf_wen, rf_addrw, rf_dinw} !== {1'b1, 5'd3, 32'hAAAA0001}) begin
            bad++;
            $display("FAIL single_write: wen %b addr %0d data %h want 1 3 aaaa0001", rf_wen, rf_addrw, rf_dinw);
        end
        tick();
        total++;
        if ({empty, rf_wen, count} !== {1'b1, 1'b0, 3'd0}) begin
            bad++;
            $display("FAIL single_drain: empty %b wen %b count %0d want 1 0 0", empty, rf_wen, count);
        end
    endtask

    task automatic test_same_rd();
        idle();
        lsu_valid = 1'b1; lsu_rd = 5'd5; lsu_data = 32'h11;
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h22;
        qa_addr = 5'd5;
        #1;
        total++;
        if ({fwd_a_hit, alu_ready} !== 2'b01) begin
            bad++;
            $display("FAIL same_rd_no_input_fwd: hit %b alu_ready %b want 0 1", fwd_a_hit, alu_ready);
        end
        tick();
        idle();
        qa_addr = 5'd5;
        #1;
        total++;
        if ({rf_wen, rf_addrw, rf_dinw} !== {1'b1, 5'd5, 32'h11}) begin
            bad++;
            $display("FAIL same_rd_first: wen %b addr %0d data %h want 1 5 11", rf_wen, rf_addrw, rf_dinw);
        end
        total++;
        if ({fwd_a_hit, fwd_a_data, count} !== {1'b1, 32'h22, 3'd2}) begin
            bad++;
            $display("FAIL same_rd_fwd: hit %b data %h count %0d want 1 22 2", fwd_a_hit, fwd_a_data, count);
        end
        tick();
        total++;
        if ({rf_wen, rf_addrw, rf_dinw, fwd_a_hit, fwd_a_data} !== {1'b1, 5'd5, 32'h22, 1'b1, 32'h22}) begin
            bad++;
            $display("FAIL same_rd_second: wen %b addr %0d data %h hit %b fdata %h want 1 5 22 1 22",
                     rf_wen, rf_addrw, rf_dinw, fwd_a_hit, fwd_a_data);
        end
        tick();
        total++;
        if ({rf_wen, fwd_a_hit, empty} !== 3'b001) begin
            bad++;
            $display("FAIL same_rd_drain: wen %b hit %b empty %b want 0 0 1", rf_wen, fwd_a_hit, empty);
        end
    endtask

    task automatic test_saturate();
        logic [4:0]  exp_rd [11];
        logic [31:0] exp_d  [11];
        for (int i = 0; i < 3; i++) begin
            exp_rd[2*i]   = 5'(i + 1);  exp_d[2*i]   = 32'h100 + 32'(i);
            exp_rd[2*i+1] = 5'(i + 17); exp_d[2*i+1] = 32'h200 + 32'(i);
        end
        for (int i = 3; i < 8; i++) begin
            exp_rd[i+3] = 5'(i + 1); exp_d[i+3] = 32'h100 + 32'(i);
        end
        for (int t = 0; t < 12; t++) begin
            idle();
            if (t < 8) begin
                lsu_valid = 1'b1; lsu_rd = 5'(t + 1);  lsu_data = 32'h100 + 32'(t);
                alu_valid = 1'b1; alu_rd = 5'(t + 17); alu_data = 32'h200 + 32'(t);
            end
            #1;
            if (t == 0) begin
                total++;
                if (rf_wen !== 1'b0) begin
                    bad++;
                    $display("FAIL sat_start_wen: got %b want 0", rf_wen);
                end
            end else begin
                total++;
                if ({rf_wen, rf_addrw, rf_dinw} !== {1'b1, exp_rd[t-1], exp_d[t-1]}) begin
                    bad++;
                    $display("FAIL sat_write_%0d: wen %b addr %0d data %h want 1 %0d %h",
                             t, rf_wen, rf_addrw, rf_dinw, exp_rd[t-1], exp_d[t-1]);
                end
            end
            if (t == 4 || t == 6) begin
                total++;
                if ({count, full, lsu_ready, alu_ready} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
                    bad++;
                    $display("FAIL sat_full_%0d: count %0d full %b lr %b ar %b want 4 1 1 0",
                             t, count, full, lsu_ready, alu_ready);
                end
            end
            tick();
        end
        idle();
        #1;
        total++;
        if ({empty, rf_wen} !== 2'b10) begin
            bad++;
            $display("FAIL sat_drain: empty %b wen %b want 1 0", empty, rf_wen);
        end
    endtask

    task automatic test_rd_zero();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        #1;
        total++;
        if (alu_ready !== 1'b1) begin
            bad++;
            $display("FAIL rd0_ready: got %b want 1", alu_ready);
        end
        tick();
        idle();
        qa_addr = 5'd0;
        #1;
        total++;
        if ({count, rf_wen, fwd_a_hit, fwd_a_data} !== {3'd0, 1'b0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL rd0_no_alloc: count %0d wen %b hit %b data %h want 0 0 0 0",
                     count, rf_wen, fwd_a_hit, fwd_a_data);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h70;
        alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h80;
        tick();
        lsu_rd = 5'd9;  lsu_data = 32'h90;
        alu_rd = 5'd10; alu_data = 32'hA0;
        tick();
        idle();
        qa_addr = 5'd9;
        #1;
        total++;
        if ({count, fwd_a_hit, fwd_a_data} !== {3'd3, 1'b1, 32'h90}) begin
            bad++;
            $display("FAIL mid_filled: count %0d hit %b data %h want 3 1 90", count, fwd_a_hit, fwd_a_data);
        end
        rst = 1'b1;
        lsu_valid = 1'b1; lsu_rd = 5'd11; lsu_data = 32'hB0;
        tick();
        rst = 1'b0;
        idle();
        qa_addr = 5'd9; qb_addr = 5'd10;
        #1;
        total++;
        if ({count, rf_wen, fwd_a_hit, fwd_b_hit, empty} !== {3'd0, 4'b0001}) begin
            bad++;
            $display("FAIL mid_reset: count %0d wen %b ha %b hb %b empty %b want 0 0 0 0 1",
                     count, rf_wen, fwd_a_hit, fwd_b_hit, empty);
        end
        tick();
        total++;
        if ({rf_wen, count} !== {1'b0, 3'd0}) begin
            bad++;
            $display("FAIL mid_discard: wen %b count %0d want 0 0", rf_wen, count);
        end
    endtask

    task automatic test_random();
        int n, f;
        logic e_lr, e_ar, e_ha, e_hb;
        logic [31:0] e_da, e_db;
        ent_t e;
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mq.delete();
        for (int c = 0; c < 10000; c++) begin
            lsu_valid = 1'($urandom_range(0, 1));
            alu_valid = 1'($urandom_range(0, 1));
            lsu_rd    = 5'($urandom_range(0, 7));
            alu_rd    = 5'($urandom_range(0, 7));
            lsu_data  = $urandom;
            alu_data  = $urandom;
            qa_addr   = 5'($urandom_range(0, 7));
            qb_addr   = 5'($urandom_range(0, 7));
            #1;
            n = mq.size();
            f = 4 - n + ((n != 0) ? 1 : 0);
            e_lr = (f >= 1);
            e_ar = (f >= 2) || ((f >= 1) && !lsu_valid);
            e_ha = 1'b0; e_hb = 1'b0; e_da = '0; e_db = '0;
            for (int k = 0; k < n; k++) begin
                if (qa_addr != 0 && mq[k].rd == qa_addr) begin e_ha = 1'b1; e_da = mq[k].d; end
                if (qb_addr != 0 && mq[k].rd == qb_addr) begin e_hb = 1'b1; e_db = mq[k].d; end
            end
            total++;
            if (n != 0) begin
                if ({rf_wen, rf_addrw, rf_dinw} !== {1'b1, mq[0].rd, mq[0].d}) begin
                    bad++;
                    $display("FAIL rand_rf c%0d: wen %b addr %0d data %h want 1 %0d %h",
                             c, rf_wen, rf_addrw, rf_dinw, mq[0].rd, mq[0].d);
                end
            end else if ({rf_wen, rf_addrw, rf_dinw} !== 38'd0) begin
                bad++;
                $display("FAIL rand_rf c%0d: wen %b addr %0d data %h want 0 0 0", c, rf_wen, rf_addrw, rf_dinw);
            end
            total++;
            if ({fwd_a_hit, fwd_a_data} !== {e_ha, e_da}) begin
                bad++;
                $display("FAIL rand_fwd_a c%0d: hit %b data %h want %b %h", c, fwd_a_hit, fwd_a_data, e_ha, e_da);
            end
            total++;
            if ({fwd_b_hit, fwd_b_data} !== {e_hb, e_db}) begin
                bad++;
                $display("FAIL rand_fwd_b c%0d: hit %b data %h want %b %h", c, fwd_b_hit, fwd_b_data, e_hb, e_db);
            end
            total++;
            if ({lsu_ready, alu_ready, count, empty, full} !== {e_lr, e_ar, 3'(n), (n == 0), (n == 4)}) begin
                bad++;
                $display("FAIL rand_ctl c%0d: lr %b ar %b count %0d empty %b full %b want %b %b %0d",
                         c, lsu_ready, alu_ready, count, empty, full, e_lr, e_ar, n);
            end
            if (n != 0) void'(mq.pop_front());
            if (lsu_valid && e_lr && lsu_rd != 0) begin e.rd = lsu_rd; e.d = lsu_data; mq.push_back(e); end
            if (alu_valid && e_ar && alu_rd != 0) begin e.rd = alu_rd; e.d = alu_data; mq.push_back(e); end
            tick();
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_single_lsu();
        test_same_rd();
        test_saturate();
        test_rd_zero();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
